sync_fifo_ctl: RTL

Parametrised single-clock FIFO, next generation of the team's wrreq/rdreq FIFO used around the systolic array datapath.
- Adds protected accesses: writes when full and reads when empty are rejected and flagged, not silently corrupting state.
- Adds a synchronous flush, a fill-level output, and programmable almost-full/almost-empty thresholds for back-pressure to the PE array feeders.
- Read data is show-ahead: q presents the head entry combinationally.

---
 rtl/sync_fifo_pkg.sv | 22 ++
 rtl/sync_fifo_mem.sv | 29 ++
 rtl/sync_fifo_ctl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared types and elaboration limits for the single-clock FIFO family.
// The sticky error-flag variant of sync_fifo_ctl is selected with SYNC_FIFO_STICKY_ERR_EN.
package sync_fifo_pkg;

  localparam int unsigned MIN_LOG_DEPTH = 1;
  localparam int unsigned MAX_LOG_DEPTH = 16;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

  // Level counter needs one extra bit to represent a completely full FIFO.
  function automatic int unsigned level_width(input int unsigned log_depth);
    return log_depth + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Storage array for sync_fifo_ctl: one synchronous write port, one asynchronous read port.
// Contents are never reset.
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LOG_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [LOG_DEPTH-1:0]  i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [LOG_DEPTH-1:0]  i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  localparam int unsigned DEPTH = 1 << LOG_DEPTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo_ctl.sv
// Single-clock show-ahead FIFO with protected accesses, flush, level and programmable thresholds.
// Define SYNC_FIFO_STICKY_ERR_EN for sticky overflow/underflow flags cleared by err_clr.
module sync_fifo_ctl
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LOG_DEPTH  = 4,
  parameter int unsigned AF_LEVEL   = (1 << LOG_DEPTH) - 2,
  parameter int unsigned AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  flush,
  input  logic                  wrreq,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  rdreq,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [LOG_DEPTH:0]    level,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  err_clr
);

  localparam int unsigned FIFO_DEPTH = 1 << LOG_DEPTH;
  localparam int unsigned LW         = level_width(LOG_DEPTH);

  localparam fifo_status_t RST_STATUS = '{
    full:         1'b0,
    empty:        1'b1,
    almost_full:  (AF_LEVEL == 0),
    almost_empty: 1'b1,
    overflow:     1'b0,
    underflow:    1'b0
  };

  if (LOG_DEPTH < MIN_LOG_DEPTH || LOG_DEPTH > MAX_LOG_DEPTH) begin : g_bad_log_depth
    $error("sync_fifo_ctl: LOG_DEPTH out of range");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > FIFO_DEPTH) begin : g_bad_af_level
    $error("sync_fifo_ctl: AF_LEVEL must be in 1..FIFO_DEPTH");
  end
  if (AE_LEVEL > FIFO_DEPTH - 1) begin : g_bad_ae_level
    $error("sync_fifo_ctl: AE_LEVEL must be in 0..FIFO_DEPTH-1");
  end

  logic [LOG_DEPTH-1:0] r_wr_ptr;
  logic [LOG_DEPTH-1:0] r_rd_ptr;
  logic [LW-1:0]        r_level;
  fifo_status_t         r_status;

  logic                 w_rd_acc;
  logic                 w_wr_acc;
  logic                 w_ovf_evt;
  logic                 w_unf_evt;
  logic                 w_mem_we;
  logic [LW-1:0]        w_level_nxt;
  fifo_status_t         w_status_nxt;

  // Full is still writable when a pop frees a slot in the same cycle.
  assign w_rd_acc  = rdreq & ~r_status.empty;
  assign w_wr_acc  = wrreq & (~r_status.full | w_rd_acc);
  assign w_ovf_evt = wrreq & ~w_wr_acc & ~flush;
  assign w_unf_evt = rdreq & ~w_rd_acc & ~flush;
  assign w_mem_we  = w_wr_acc & ~flush & rstn;

  always_comb begin
    w_level_nxt = r_level;
    if (flush) begin
      w_level_nxt = '0;
    end else begin
      case ({w_wr_acc, w_rd_acc})
        2'b10:   w_level_nxt = r_level + LW'(1);
        2'b01:   w_level_nxt = r_level - LW'(1);
        default: w_level_nxt = r_level;
      endcase
    end
  end

  // Flags are precomputed from the next level so they register alongside it.
  always_comb begin
    w_status_nxt              = RST_STATUS;
    w_status_nxt.full         = (w_level_nxt == LW'(FIFO_DEPTH));
    w_status_nxt.empty        = (w_level_nxt == '0);
    w_status_nxt.almost_full  = (w_level_nxt >= LW'(AF_LEVEL));
    w_status_nxt.almost_empty = (w_level_nxt <= LW'(AE_LEVEL));
`ifdef SYNC_FIFO_STICKY_ERR_EN
    w_status_nxt.overflow     = w_ovf_evt | (r_status.overflow  & ~err_clr);
    w_status_nxt.underflow    = w_unf_evt | (r_status.underflow & ~err_clr);
`else
    w_status_nxt.overflow     = w_ovf_evt;
    w_status_nxt.underflow    = w_unf_evt;
`endif
  end

`ifndef SYNC_FIFO_STICKY_ERR_EN
  logic w_unused_err_clr;
  assign w_unused_err_clr = err_clr;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_status <= RST_STATUS;
    end else begin
      r_level  <= w_level_nxt;
      r_status <= w_status_nxt;
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_wr_acc) r_wr_ptr <= r_wr_ptr + LOG_DEPTH'(1);
        if (w_rd_acc) r_rd_ptr <= r_rd_ptr + LOG_DEPTH'(1);
      end
    end
  end

  sync_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .LOG_DEPTH  (LOG_DEPTH)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (data),
    .i_raddr (r_rd_ptr),
    .o_rdata (q)
  );

  assign full         = r_status.full;
  assign empty        = r_status.empty;
  assign almost_full  = r_status.almost_full;
  assign almost_empty = r_status.almost_empty;
  assign overflow     = r_status.overflow;
  assign underflow    = r_status.underflow;
  assign level        = r_level;

endmodule
